// File: rtl/despachador_traccion.sv
// despachador_traccion: owns the UART rdy/rdy_clr handshake, parses ASCII
// frames <letter><1-3 digits><terminator> and dispatches duty/direction to
// the addressed traction channel. Each channel has a watchdog that zeroes
// its duty when commands stop arriving.
module despachador_traccion #(
    parameter int          NUM_CANALES       = 4,
    parameter logic [7:0]  LETRA_BASE        = 8'd65,
    parameter logic [7:0]  CARACTER_ADELANTE = 8'd35,
    parameter logic [7:0]  CARACTER_ATRAS    = 8'd33,
    parameter int          TIMEOUT_CICLOS    = 25000000
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       rdy,
    input  logic [7:0]                 dout,
    output logic                       rdy_clr,
    output logic [8*NUM_CANALES-1:0]   SALIDA_AL_MOTOR,
    output logic [NUM_CANALES-1:0]     SALIDA_DIRECCION,
    output logic [NUM_CANALES-1:0]     CANAL_ACTIVO,
    output logic                       ERROR_TRAMA
);

    localparam int CH_W = (NUM_CANALES > 1) ? $clog2(NUM_CANALES) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [WD_W-1:0] WD_CARGA = WD_W'(TIMEOUT_CICLOS);

    typedef enum logic {
        ESPERA_LETRA  = 1'b0,
        ESPERA_DIGITO = 1'b1
    } estado_t;

    estado_t           r_estado;
    estado_t           w_estado_next;
    logic [CH_W-1:0]   r_canal;
    logic [CH_W-1:0]   w_canal_next;
    logic [9:0]        r_acc;
    logic [9:0]        w_acc_next;
    logic [1:0]        r_ndig;
    logic [1:0]        w_ndig_next;
    logic              r_rdy_clr;
    logic              r_error;
    logic              w_error_next;
    logic              w_escribir;
    logic              w_dir_val;

    // Byte decode helpers
    logic              w_acepta;
    logic              w_es_letra;
    logic              w_es_digito;
    logic              w_es_term;
    logic [CH_W-1:0]   w_canal_letra;
    logic [3:0]        w_digito;

    // A byte is taken only when rdy is up and we are not in the clear cycle
    assign w_acepta      = rdy && !r_rdy_clr;
    assign w_es_letra    = ({1'b0, dout} >= {1'b0, LETRA_BASE}) &&
                           ({1'b0, dout} < ({1'b0, LETRA_BASE} + 9'(NUM_CANALES)));
    assign w_es_digito   = (dout >= 8'd48) && (dout <= 8'd57);
    assign w_es_term     = (dout == CARACTER_ADELANTE) || (dout == CARACTER_ATRAS);
    assign w_canal_letra = CH_W'(dout - LETRA_BASE);
    assign w_digito      = 4'(dout - 8'd48);

    // Parser state and handshake registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_estado  <= ESPERA_LETRA;
            r_canal   <= '0;
            r_acc     <= '0;
            r_ndig    <= '0;
            r_rdy_clr <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_canal   <= w_canal_next;
            r_acc     <= w_acc_next;
            r_ndig    <= w_ndig_next;
            r_rdy_clr <= w_acepta;
            r_error   <= w_error_next;
        end
    end

    // Next-state logic: frame parsing, rejection and dispatch strobe
    always_comb begin
        w_estado_next = r_estado;
        w_canal_next  = r_canal;
        w_acc_next    = r_acc;
        w_ndig_next   = r_ndig;
        w_error_next  = 1'b0;
        w_escribir    = 1'b0;
        w_dir_val     = 1'b0;
        if (w_acepta) begin
            case (r_estado)
                ESPERA_LETRA: begin
                    if (w_es_letra) begin
                        w_canal_next  = w_canal_letra;
                        w_acc_next    = '0;
                        w_ndig_next   = '0;
                        w_estado_next = ESPERA_DIGITO;
                    end
                end
                ESPERA_DIGITO: begin
                    if (w_es_letra) begin
                        // A new letter restarts the frame without an error
                        w_canal_next  = w_canal_letra;
                        w_acc_next    = '0;
                        w_ndig_next   = '0;
                    end else if (w_es_digito) begin
                        if (r_ndig != 2'd3) begin
                            w_acc_next  = (r_acc * 10'd10) + {6'd0, w_digito};
                            w_ndig_next = r_ndig + 2'd1;
                        end else begin
                            w_error_next  = 1'b1;
                            w_estado_next = ESPERA_LETRA;
                        end
                    end else if (w_es_term) begin
                        if ((r_ndig != 2'd0) && (r_acc <= 10'd255)) begin
                            w_escribir = 1'b1;
                            w_dir_val  = (dout == CARACTER_ATRAS);
                        end else begin
                            w_error_next = 1'b1;
                        end
                        w_estado_next = ESPERA_LETRA;
                    end else begin
                        w_error_next  = 1'b1;
                        w_estado_next = ESPERA_LETRA;
                    end
                end
                default: w_estado_next = ESPERA_LETRA;
            endcase
        end
    end

    assign rdy_clr     = r_rdy_clr;
    assign ERROR_TRAMA = r_error;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANALES; gi++) begin : g_canal
            logic [7:0]      r_duty;
            logic            r_dir;
            logic            r_activo;
            logic [WD_W-1:0] r_wd;
            logic            w_cmd;

            assign w_cmd = w_escribir && (r_canal == CH_W'(gi));

            // Channel outputs and watchdog; a command on the expiry edge wins
            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    r_duty   <= 8'd0;
                    r_dir    <= 1'b0;
                    r_activo <= 1'b0;
                    r_wd     <= '0;
                end else if (w_cmd) begin
                    r_duty   <= r_acc[7:0];
                    r_dir    <= w_dir_val;
                    r_activo <= 1'b1;
                    r_wd     <= WD_CARGA;
                end else if (r_wd != '0) begin
                    r_wd <= r_wd - WD_W'(1);
                    if (r_wd == WD_W'(1)) begin
                        r_duty   <= 8'd0;
                        r_activo <= 1'b0;
                    end
                end
            end

            assign SALIDA_AL_MOTOR[8*gi +: 8] = r_duty;
            assign SALIDA_DIRECCION[gi]       = r_dir;
            assign CANAL_ACTIVO[gi]           = r_activo;
        end
    endgenerate

endmodule

// File: tb/tb_despachador_traccion.sv
// Directed bench for despachador_traccion with a scoreboard: each byte sent
// queues the expected outputs, and a monitor compares on every rdy_clr pulse.
module tb_despachador_traccion;

    localparam int NC = 4;
    localparam int TO = 100;

    logic            CLOCK_50 = 1'b0;
    logic            RESET    = 1'b1;
    logic            rdy      = 1'b0;
    logic [7:0]      dout     = 8'd0;
    logic            rdy_clr;
    logic [8*NC-1:0] SALIDA_AL_MOTOR;
    logic [NC-1:0]   SALIDA_DIRECCION;
    logic [NC-1:0]   CANAL_ACTIVO;
    logic            ERROR_TRAMA;

    despachador_traccion #(
        .NUM_CANALES       (NC),
        .LETRA_BASE        (8'd65),
        .CARACTER_ADELANTE (8'd35),
        .CARACTER_ATRAS    (8'd33),
        .TIMEOUT_CICLOS    (TO)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .RESET            (RESET),
        .rdy              (rdy),
        .dout             (dout),
        .rdy_clr          (rdy_clr),
        .SALIDA_AL_MOTOR  (SALIDA_AL_MOTOR),
        .SALIDA_DIRECCION (SALIDA_DIRECCION),
        .CANAL_ACTIVO     (CANAL_ACTIVO),
        .ERROR_TRAMA      (ERROR_TRAMA)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [8*NC-1:0] duty;
        logic [NC-1:0]   dir;
        logic [NC-1:0]   act;
        logic            err;
        logic [7:0]      b;
    } esperado_t;

    esperado_t       sb[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    int              t_last  = 0;
    logic [8*NC-1:0] exp_duty = '0;
    logic [NC-1:0]   exp_dir  = '0;
    logic [NC-1:0]   exp_act  = '0;

    // Edge counter: at a negedge, cyc equals the number of the edge just passed
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Monitor: one scoreboard pop per accepted byte
    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            if (ERROR_TRAMA && !rdy_clr) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL error_sin_byte: ERROR_TRAMA=1 without rdy_clr at cycle %0d", cyc);
            end
            if (rdy_clr) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rdy_clr_inesperado: pulse with empty scoreboard at cycle %0d", cyc);
                end else begin
                    esperado_t e;
                    e = sb.pop_front();
                    if (SALIDA_AL_MOTOR !== e.duty || SALIDA_DIRECCION !== e.dir ||
                        CANAL_ACTIVO !== e.act || ERROR_TRAMA !== e.err) begin
                        n_fail++;
                        $display("[TB] FAIL byte '%c': got duty=%h dir=%b act=%b err=%b, want duty=%h dir=%b act=%b err=%b",
                                 e.b, SALIDA_AL_MOTOR, SALIDA_DIRECCION, CANAL_ACTIVO, ERROR_TRAMA,
                                 e.duty, e.dir, e.act, e.err);
                    end else begin
                        $display("[TB] ok byte '%c' cyc=%0d duty=%h dir=%b act=%b err=%b",
                                 e.b, cyc, SALIDA_AL_MOTOR, SALIDA_DIRECCION, CANAL_ACTIVO, ERROR_TRAMA);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic err);
        esperado_t e;
        e.duty = exp_duty;
        e.dir  = exp_dir;
        e.act  = exp_act;
        e.err  = err;
        e.b    = b;
        sb.push_back(e);
    endtask

    // Called at a negedge; byte is accepted on the next posedge
    task automatic send_byte(input logic [7:0] b, input logic err);
        bit got;
        got  = 1'b0;
        dout = b;
        rdy  = 1'b1;
        push(b, err);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge CLOCK_50);
            if (rdy_clr) got = 1'b1;
        end
        rdy = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL timeout_rdy_clr: byte '%c' never accepted", b);
        end else begin
            t_last = cyc;
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic send_frame(input string s, input int err_idx, input int upd_ch,
                              input logic [7:0] d, input logic dr);
        for (int i = 0; i < s.len(); i++) begin
            if (i == s.len() - 1 && upd_ch >= 0) begin
                exp_duty[8*upd_ch +: 8] = d;
                exp_dir[upd_ch]         = dr;
                exp_act[upd_ch]         = 1'b1;
            end
            send_byte(s[i], i == err_idx);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RESET = 1'b1;
        rdy   = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        RESET    = 1'b0;
        exp_duty = '0;
        exp_dir  = '0;
        exp_act  = '0;
        chk("reset_state", {SALIDA_AL_MOTOR, SALIDA_DIRECCION, CANAL_ACTIVO, rdy_clr, ERROR_TRAMA}, 64'd0);
    endtask

    initial begin
        int t1;
        do_reset();

        // Single frame on channel 1
        send_frame("B128#", -1, 1, 8'd128, 1'b0);
        chk("b128_duty", SALIDA_AL_MOTOR, 64'h0000_8000);
        chk("b128_act", CANAL_ACTIVO, 64'b0010);

        // Two channels, reverse and forward
        do_reset();
        send_frame("A255!", -1, 0, 8'd255, 1'b1);
        send_frame("D7#", -1, 3, 8'd7, 1'b0);
        chk("a255_d7_duty", SALIDA_AL_MOTOR, 64'h0700_00FF);
        chk("a255_d7_dir", SALIDA_DIRECCION, 64'b0001);

        // Rejected frames
        do_reset();
        send_frame("A256#", 4, -1, 8'd0, 1'b0);
        send_frame("A#", 1, -1, 8'd0, 1'b0);
        send_frame("A1234#", 4, -1, 8'd0, 1'b0);
        send_frame("A1x#", 2, -1, 8'd0, 1'b0);

        // Letter restart and ignored bytes while waiting for a letter
        do_reset();
        send_frame("C50#", -1, 2, 8'd50, 1'b0);
        send_frame("AB9#", -1, 1, 8'd9, 1'b0);
        send_frame("Z5", -1, -1, 8'd0, 1'b0);
        chk("c50_b9_duty", SALIDA_AL_MOTOR, 64'h0032_0900);

        // rdy held high: acceptance on alternate cycles only
        dout = 8'd65;
        rdy  = 1'b1;
        push(8'd65, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLOCK_50);
            chk("rdy_clr_alterna", {63'd0, rdy_clr}, 64'(k % 2));
            if (k % 2 == 0) push(8'd65, 1'b0);
        end
        rdy = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // Watchdog expiry exactly TO cycles after the update edge
        do_reset();
        send_frame("A200!", -1, 0, 8'd200, 1'b1);
        t1 = t_last;
        while (cyc < t1 + TO - 1) @(negedge CLOCK_50);
        chk("wd_antes_duty", {SALIDA_AL_MOTOR[7:0], CANAL_ACTIVO[0]}, {55'd0, 8'd200, 1'b1});
        @(negedge CLOCK_50);
        chk("wd_expira", {SALIDA_AL_MOTOR[7:0], CANAL_ACTIVO[0], SALIDA_DIRECCION[0]}, {54'd0, 8'd0, 1'b0, 1'b1});
        exp_duty[7:0] = 8'd0;
        exp_act[0]    = 1'b0;

        // Command landing on the expiry edge wins and reloads the counter
        send_frame("A200!", -1, 0, 8'd200, 1'b1);
        t1 = t_last;
        send_frame("A90", -1, -1, 8'd0, 1'b0);
        while (cyc < t1 + TO - 1) @(negedge CLOCK_50);
        exp_duty[7:0] = 8'd90;
        exp_dir[0]    = 1'b0;
        exp_act[0]    = 1'b1;
        send_byte(8'd35, 1'b0);
        chk("wd_colision_flanco", 64'(t_last), 64'(t1 + TO));
        while (cyc < t1 + 2*TO - 1) @(negedge CLOCK_50);
        chk("wd_recarga_activo", {SALIDA_AL_MOTOR[7:0], CANAL_ACTIVO[0]}, {55'd0, 8'd90, 1'b1});
        @(negedge CLOCK_50);
        chk("wd_recarga_expira", {SALIDA_AL_MOTOR[7:0], CANAL_ACTIVO[0]}, 64'd0);
        exp_duty[7:0] = 8'd0;
        exp_act[0]    = 1'b0;

        // Reset mid-frame abandons the partial frame
        send_frame("B12", -1, -1, 8'd0, 1'b0);
        do_reset();
        send_frame("#", -1, -1, 8'd0, 1'b0);
        send_frame("B5#", -1, 1, 8'd5, 1'b0);
        chk("b5_tras_reset", SALIDA_AL_MOTOR, 64'h0000_0500);

        repeat (2) @(negedge CLOCK_50);
        chk("scoreboard_vacio", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
